// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// No logic, so no latency.
// No flow control.
package regfile_dump_pkg;

  // Dump sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP,
    FINISH
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;

  // Byte lane idx of a 32-bit word, lane 0 being the least significant
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/regfile_dump_uart_tx.sv
// Walks the register file from x0 upward and sends each word as four 8N1 UART frames, LSB byte first.
// Per register: 1 fetch cycle + 40*CLKS_PER_BIT bit cycles; done pulses one cycle after the last stop bit.
// No backpressure on the line; dump_start is ignored (not queued) while a dump is in progress or finishing.
module regfile_dump_uart_tx
  import regfile_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk_o,
  input  logic        rst_n,
  input  logic        dump_start,
  output logic [4:0]  raddr,
  input  logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_REG  = 5'(NUM_REGS - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [4:0]    reg_idx;
  logic [31:0]   word_q;
  logic [7:0]    cur_byte;
  logic          baud_end;

  // The read address is the register index itself, so it only moves when reg_idx does
  assign raddr    = reg_idx;
  assign cur_byte = word_byte(word_q, byte_idx);
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Dump sequencer: register/byte walk plus bit timing; tx, busy and done are all registered here
  always_ff @(posedge clk_o or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      reg_idx  <= '0;
      word_q   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            reg_idx  <= '0;
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        // Snapshot the word once; later writes to it are deliberately not seen
        FETCH: begin
          word_q   <= rdata;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Back-to-back frames within a word; a fetch cycle separates words
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end else if (reg_idx < LAST_REG) begin
              reg_idx  <= reg_idx + 5'd1;
              byte_idx <= '0;
              state    <= FETCH;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_uart_tx.sv
// Bench for regfile_dump_uart_tx: a 2-register and a 32-register instance at 4 clocks per bit.
// Stimulus pushes expected bytes into a queue; a UART monitor decodes tx and pops/compares.
// All waits are bounded by cycle budgets.
module tb_regfile_dump_uart_tx;

  localparam int CPB = 4;

  logic clk_o = 1'b0;
  always #5 clk_o = ~clk_o;

  logic        rst_n;
  logic        start_a, start_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] rf_a [2];
  logic [31:0] rf_b [32];

  assign rdata_a = rf_a[raddr_a[0]];
  assign rdata_b = rf_b[raddr_b];

  regfile_dump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(2)) dut_a (
    .clk_o      (clk_o),
    .rst_n      (rst_n),
    .dump_start (start_a),
    .raddr      (raddr_a),
    .rdata      (rdata_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  regfile_dump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(32)) dut_b (
    .clk_o      (clk_o),
    .rst_n      (rst_n),
    .dump_start (start_b),
    .raddr      (raddr_b),
    .rdata      (rdata_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  int total;
  int bad;
  int rx_cnt;
  int n;
  int busy_run;
  int busy_seen;
  int done_cnt;
  logic mon_en;
  logic sel;
  logic tx_s;
  logic [7:0] exp_q [$];
  logic [31:0] w;

  assign tx_s = sel ? tx_b : tx_a;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_o);
    #1;
  endtask

  // UART 8N1 receiver on the selected line, sampled on falling edges
  initial begin : monitor
    logic [39:0] s;
    logic [7:0]  b;
    logic        chk;
    logic        ok;
    logic        abort;
    forever begin
      @(negedge clk_o);
      if (rst_n && !tx_s) begin
        chk   = mon_en;
        abort = 1'b0;
        s     = '0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk_o);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
          s[i] = tx_s;
        end
        if (!abort && chk) begin
          ok = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (s[i] != 1'b0) ok = 1'b0;
            if (s[36+i] != 1'b1) ok = 1'b0;
          end
          for (int k = 0; k < 8; k++) begin
            b[k] = s[4+4*k];
            for (int j = 1; j < 4; j++)
              if (s[4+4*k+j] != s[4+4*k]) ok = 1'b0;
          end
          check("frame_shape", {31'd0, ok}, 32'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %02h expected none", b);
          end else begin
            check("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
          rx_cnt++;
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; rx_cnt = 0;
    mon_en = 1'b1; sel = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    rst_n = 1'b0;
    rf_a[0] = 32'h0; rf_a[1] = 32'h0;
    for (int i = 0; i < 32; i++) rf_b[i] = i * 32'h01010101;

    // 1: reset values and quiet idle
    repeat (3) @(posedge clk_o);
    #1 rst_n = 1'b1;
    tick();
    check("rst_tx_a", {31'd0, tx_a}, 32'd1);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_raddr_a", {27'd0, raddr_a}, 32'd0);
    check("rst_tx_b", {31'd0, tx_b}, 32'd1);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    repeat (10) tick();
    check("idle_tx_b", {31'd0, tx_b}, 32'd1);
    check("idle_busy_a", {31'd0, busy_a}, 32'd0);

    // 2: byte order, framing and done timing with two registers
    rf_a[1] = 32'hDEADBEEF;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t2_busy_fetch", {31'd0, busy_a}, 32'd1);
    check("t2_raddr_fetch", {27'd0, raddr_a}, 32'd0);
    n = 0;
    while (!done_a && n < 400) begin tick(); n++; end
    check("t2_done_cycle", n, 32'd322);
    check("t2_busy_finish", {31'd0, busy_a}, 32'd0);
    tick();
    check("t2_done_pulse", {31'd0, done_a}, 32'd0);
    repeat (5) tick();
    check("t2_rx_cnt", rx_cnt, 32'd8);
    check("t2_queue_left", exp_q.size(), 32'd0);

    // 3/4/5: full dump, ignored starts, snapshot rule
    sel = 1'b1; rx_cnt = 0;
    for (int r = 0; r < 32; r++) begin
      w = (r == 10) ? 32'h12345678 : r * 32'h01010101;
      for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    end
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0; busy_run = 0; done_cnt = 0;
    while (!done_b && n < 6000) begin
      if (busy_b) busy_run++;
      if (n == 500) begin rf_b[3] = 32'hFFFFFFFF; rf_b[10] = 32'h12345678; end
      if (n == 804) check("t3_raddr4", {27'd0, raddr_b}, 32'd4);
      if (n == 805) check("t3_raddr5", {27'd0, raddr_b}, 32'd5);
      if (n == 812) start_b = 1'b1;
      if (n == 813) start_b = 1'b0;
      tick(); n++;
    end
    if (done_b) done_cnt++;
    check("t3_done_cycle", n, 32'd5152);
    check("t3_busy_run", busy_run, 32'd5152);
    start_b = 1'b1; tick(); start_b = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy_b) busy_seen++;
      if (done_b) done_cnt++;
      tick();
    end
    check("t4_no_restart", busy_seen, 32'd0);
    check("t3_done_count", done_cnt, 32'd1);
    check("t3_rx_cnt", rx_cnt, 32'd128);
    check("t3_queue_left", exp_q.size(), 32'd0);

    // 6: reset mid data bit of register 7, then restart from x0
    for (int i = 0; i < 32; i++) rf_b[i] = i * 32'h01010101;
    mon_en = 1'b0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (n < 1145) begin tick(); n++; end
    check("t6_raddr7", {27'd0, raddr_b}, 32'd7);
    check("t6_tx_bit3", {31'd0, tx_b}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_tx", {31'd0, tx_b}, 32'd1);
    check("t6_async_busy", {31'd0, busy_b}, 32'd0);
    check("t6_async_raddr", {27'd0, raddr_b}, 32'd0);
    repeat (2) @(posedge clk_o);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    check("t6_idle_busy", {31'd0, busy_b}, 32'd0);
    exp_q.delete();
    rx_cnt = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h01);
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("t6_restart_busy", {31'd0, busy_b}, 32'd1);
    check("t6_restart_raddr", {27'd0, raddr_b}, 32'd0);
    n = 0;
    while (rx_cnt < 8 && n < 500) begin tick(); n++; end
    mon_en = 1'b0;
    check("t6_rx_cnt", rx_cnt, 32'd8);
    check("t6_queue_left", exp_q.size(), 32'd0);
    rst_n = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
